// File: rtl/mem_write_checker.sv
// Self-check monitor for a core's data-memory write port: matches observed writes
// against a programmed table of expected (address, data) pairs, with a watchdog.
module mem_write_checker #(
  parameter int              ADDR_W  = 32,
  parameter int              DATA_W  = 32,
  parameter int              N_EXP   = 4,
  parameter int              TIMEOUT = 1024,
  parameter bit              IGN_EN  = 1'b1,
  parameter logic [ADDR_W-1:0] IGN_ADR = ADDR_W'(96),
  parameter int              MODE    = 0,
  localparam int             IDX_W   = (N_EXP > 1) ? $clog2(N_EXP) : 1,
  localparam int             CNT_W   = $clog2(N_EXP + 1),
  localparam int             CYC_W   = $clog2(TIMEOUT + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              prog_we,
  input  logic [IDX_W-1:0]  prog_idx,
  input  logic [ADDR_W-1:0] prog_adr,
  input  logic [DATA_W-1:0] prog_data,
  input  logic [CNT_W-1:0]  num_exp,
  input  logic              MemWrite,
  input  logic [ADDR_W-1:0] DataAdr,
  input  logic [DATA_W-1:0] WriteData,
  output logic              busy,
  output logic              pass,
  output logic              fail,
  output logic [1:0]        fail_code,
  output logic [CNT_W-1:0]  match_cnt,
  output logic [CYC_W-1:0]  cycle_cnt
);

  typedef enum logic [1:0] {IDLE, RUN, PASS, FAIL} state_t;

  typedef struct packed {
    logic [ADDR_W-1:0] adr;
    logic [DATA_W-1:0] data;
  } expEntry_t;

  expEntry_t        expTable [N_EXP];
  expEntry_t        cur;
  state_t           state, stateNxt;
  logic [CNT_W-1:0] nReg, nNxt, matchNxt, numClamped;
  logic [CYC_W-1:0] cycNxt, cycInc;
  logic [1:0]       codeNxt;
  logic             ignored, hit, timedOut, realWrite;

  // Table has no reset so a reset between runs keeps the programmed sequence.
  always_ff @(posedge clk) begin
    if (state == IDLE && prog_we && 32'(prog_idx) < N_EXP)
      expTable[prog_idx] <= '{adr: prog_adr, data: prog_data};
  end

  assign numClamped = (num_exp > CNT_W'(N_EXP)) ? CNT_W'(N_EXP) : num_exp;
  assign cur        = expTable[match_cnt[IDX_W-1:0]];
  assign ignored    = MemWrite && IGN_EN && (DataAdr == IGN_ADR);
  assign realWrite  = MemWrite && !ignored;
  // An unknown compare result falls to the miss path.
  assign hit        = (DataAdr == cur.adr) && (WriteData == cur.data);
  assign cycInc     = (cycle_cnt == CYC_W'(TIMEOUT)) ? cycle_cnt : cycle_cnt + 1'b1;
  assign timedOut   = (cycInc == CYC_W'(TIMEOUT));

  always_comb begin
    stateNxt = state;
    nNxt     = nReg;
    matchNxt = match_cnt;
    cycNxt   = cycle_cnt;
    codeNxt  = fail_code;
    unique case (state)
      RUN: begin
        cycNxt = cycInc;
        if (nReg == '0) begin
          stateNxt = PASS;
        end else if (realWrite && hit) begin
          matchNxt = match_cnt + 1'b1;
          if (matchNxt == nReg) begin
            stateNxt = PASS;
          end else if (timedOut) begin
            stateNxt = FAIL;
            codeNxt  = 2'd2;
          end
        end else if (realWrite && MODE == 0) begin
          stateNxt = FAIL;
          codeNxt  = 2'd1;
        end else if (timedOut) begin
          stateNxt = FAIL;
          codeNxt  = 2'd2;
        end
      end
      default: begin
        if (start) begin
          stateNxt = RUN;
          nNxt     = numClamped;
          matchNxt = '0;
          cycNxt   = '0;
          codeNxt  = 2'd0;
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      nReg      <= '0;
      match_cnt <= '0;
      cycle_cnt <= '0;
      fail_code <= 2'd0;
      busy      <= 1'b0;
      pass      <= 1'b0;
      fail      <= 1'b0;
    end else begin
      state     <= stateNxt;
      nReg      <= nNxt;
      match_cnt <= matchNxt;
      cycle_cnt <= cycNxt;
      fail_code <= codeNxt;
      busy      <= (stateNxt == RUN);
      pass      <= (stateNxt == PASS);
      fail      <= (stateNxt == FAIL);
    end
  end

endmodule
